// File: rtl/uart_pkg.sv
// Shared constants for the 8N1 UART receive path: FSM encodings,
// frame geometry and the default oversampling ratio.
package uart_pkg;

  // Default: 115200 bit/s at the nominal system clock.
  localparam int CLK_PER_HALF_BIT_DEF = 435;

  // 8N1 frame: one start bit, eight data bits LSB first, one stop bit.
  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;

  // Receive FSM state encodings.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Counter terminal value for a span of n half-bits.
  function automatic logic [31:0] half_bits_last(input int half_bit, input int n);
    return 32'(half_bit * n - 1);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 byte receiver: two-flop input synchronizer, bit-timing FSM and
// registered byte outputs. Also exports single-cycle accept/reject
// strobes at the stop-bit sample edge for downstream packers.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEF
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rxd_i,
  output logic [7:0] rdata_o,
  output logic       rdata_valid_o,
  output logic       ferr_o,
  output logic       byte_ok_o,
  output logic       byte_bad_o,
  output logic [7:0] byte_o
);

  localparam logic [31:0] E_HALF = half_bits_last(CLK_PER_HALF_BIT, 1);
  localparam logic [31:0] E_BIT  = half_bits_last(CLK_PER_HALF_BIT, 2);

  logic       rxd_meta_q, rxd_s_q;
  logic [1:0] state_q, state_d;
  logic [31:0] ctr_q, ctr_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rdata_valid_q, rdata_valid_d;
  logic       ferr_q, ferr_d;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Bit-timing FSM: start bit checked at mid-bit, then one full bit period
  // between samples so every later sample also lands mid-bit.
  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q + 32'd1;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    ferr_d        = 1'b0;
    byte_ok_o     = 1'b0;
    byte_bad_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ctr_d = 32'd0;
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (ctr_q == E_HALF) begin
          ctr_d     = 32'd0;
          bit_idx_d = 3'd0;
          // A line that is high again at mid start bit was a glitch.
          state_d   = rxd_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (ctr_q == E_BIT) begin
          ctr_d     = 32'd0;
          shreg_d   = {rxd_s_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (ctr_q == E_BIT) begin
          // Leave at mid stop bit so a back-to-back start bit is not missed.
          ctr_d   = 32'd0;
          state_d = S_IDLE;
          if (rxd_s_q) begin
            rdata_d       = shreg_q;
            rdata_valid_d = 1'b1;
            byte_ok_o     = 1'b1;
          end else begin
            ferr_d     = 1'b1;
            byte_bad_o = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ctr_d   = 32'd0;
      end
    endcase
  end

  // FSM and byte-output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      ctr_q         <= 32'd0;
      bit_idx_q     <= 3'd0;
      shreg_q       <= 8'd0;
      rdata_q       <= 8'd0;
      rdata_valid_q <= 1'b0;
      ferr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      ferr_q        <= ferr_d;
    end
  end

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign ferr_o        = ferr_q;
  assign byte_o        = shreg_q;

endmodule

// File: rtl/uart_rx_word_loader.sv
// UART-to-RAM loader: packs four received bytes little-endian into a
// 32-bit word and issues one write strobe per word with an
// auto-incrementing word address.
module uart_rx_word_loader
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEF,
  parameter int ADDR_W           = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic [7:0]        rdata,
  output logic              rdata_valid,
  output logic              ferr,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic [31:0]       word_count
);

  logic       byte_ok, byte_bad;
  logic [7:0] byte_val;

  uart_rx_core #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_core (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .rxd_i         (rxd),
    .rdata_o       (rdata),
    .rdata_valid_o (rdata_valid),
    .ferr_o        (ferr),
    .byte_ok_o     (byte_ok),
    .byte_bad_o    (byte_bad),
    .byte_o        (byte_val)
  );

  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       wd_q, wd_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       word_count_q, word_count_d;

  // Word packer: accepted bytes fill wd LSB first; a framing error drops
  // the partial word. The address advances in the cycle after the strobe.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    wd_d         = wd_q;
    we_d         = 1'b0;
    wa_d         = wa_q;
    word_count_d = word_count_q;
    if (byte_ok) begin
      wd_d[{byte_cnt_q, 3'b000} +: 8] = byte_val;
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) we_d = 1'b1;
    end else if (byte_bad) begin
      byte_cnt_d = 2'd0;
    end
    if (we_q) begin
      wa_d         = wa_q + ADDR_W'(1);
      word_count_d = word_count_q + 32'd1;
    end
  end

  // Packer and address registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt_q   <= 2'd0;
      wd_q         <= 32'd0;
      we_q         <= 1'b0;
      wa_q         <= '0;
      word_count_q <= 32'd0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      wd_q         <= wd_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      word_count_q <= word_count_d;
    end
  end

  assign we         = we_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_uart_rx_word_loader.sv
// Scoreboard bench for uart_rx_word_loader. Stimulus pushes expected bytes
// and words; a negedge monitor pops and compares whenever the DUT strobes.
// A second instance with a 2-bit address checks address wrap-around.
module tb_uart_rx_word_loader;
  localparam int H      = 4;
  localparam int BIT_NS = 2 * H * 10;   // 10-unit clock period

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rxd = 1'b1;
  logic [7:0]  rdata, rdata2;
  logic        rdata_valid, rdata_valid2;
  logic        ferr, ferr2;
  logic        we, we2;
  logic [14:0] wa;
  logic [1:0]  wa2;
  logic [31:0] wd, wd2, word_count, word_count2;

  always #5 clk = ~clk;

  uart_rx_word_loader #(.CLK_PER_HALF_BIT(H), .ADDR_W(15)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rdata(rdata), .rdata_valid(rdata_valid),
    .ferr(ferr), .we(we), .wa(wa), .wd(wd), .word_count(word_count));

  uart_rx_word_loader #(.CLK_PER_HALF_BIT(H), .ADDR_W(2)) dut_a2 (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rdata(rdata2), .rdata_valid(rdata_valid2),
    .ferr(ferr2), .we(we2), .wa(wa2), .wd(wd2), .word_count(word_count2));

  int pass_cnt = 0;
  int total_cnt = 0;

  // scoreboard state
  logic [7:0]  exp_bytes[$];
  logic [63:0] exp_words[$];   // {word, index}
  logic [31:0] acc_word;
  int          acc_n = 0;
  int          word_idx = 0;
  int          exp_ferr = 0;
  int          ferr_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    acc_word[8*acc_n +: 8] = b;
    acc_n++;
    if (acc_n == 4) begin
      exp_words.push_back({acc_word, 32'(word_idx)});
      word_idx++;
      acc_n = 0;
    end
  endtask

  // Frame starts 1 unit before a clock edge so sampling phase is repeatable.
  task automatic send_frame(input logic [7:0] b, input int bit_ns, input bit stop_ok, input int gap_ns);
    @(posedge clk);
    #9;
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    if (stop_ok) begin
      rxd = 1'b1;
      #(bit_ns);
    end else begin
      // Low long enough to be sampled, high again before the receiver
      // looks for a new start bit.
      rxd = 1'b0;
      #50;
      rxd = 1'b1;
      #(bit_ns);
    end
    #(gap_ns);
  endtask

  task automatic send_good(input logic [7:0] b, input int bit_ns, input int gap_ns);
    expect_byte(b);
    send_frame(b, bit_ns, 1'b1, gap_ns);
  endtask

  task automatic send_bad(input logic [7:0] b);
    exp_ferr++;
    acc_n = 0;
    send_frame(b, BIT_NS, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, 64'(rdata), 64'd0);
    check({tag, "_rdata_valid"}, 64'(rdata_valid), 64'd0);
    check({tag, "_ferr"}, 64'(ferr), 64'd0);
    check({tag, "_we"}, 64'(we), 64'd0);
    check({tag, "_wa"}, 64'(wa), 64'd0);
    check({tag, "_wd"}, 64'(wd), 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'd0);
    check({tag, "_a2_outputs"}, {rdata2, rdata_valid2, ferr2, we2, wa2, wd2[15:0], word_count2[15:0]}, 64'd0);
  endtask

  task automatic clear_model();
    exp_bytes.delete();
    exp_words.delete();
    acc_n = 0;
    word_idx = 0;
    exp_ferr = 0;
    ferr_seen = 0;
  endtask

  task automatic apply_reset(input string tag);
    rxd = 1'b1;
    rstn = 1'b0;
    #1;
    check_reset_outputs(tag);
    clear_model();
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // End-of-test drain and totals.
  task automatic finish_test(input string tag);
    repeat (40) @(negedge clk);
    check({tag, "_bytes_left"}, 64'(exp_bytes.size()), 64'd0);
    check({tag, "_words_left"}, 64'(exp_words.size()), 64'd0);
    check({tag, "_ferr_count"}, 64'(ferr_seen), 64'(exp_ferr));
    check({tag, "_word_count"}, 64'(word_count), 64'(word_idx));
    check({tag, "_wa_final"}, 64'(wa), 64'(word_idx % 32768));
    check({tag, "_a2_word_count"}, 64'(word_count2), 64'(word_idx));
    check({tag, "_a2_wa_final"}, 64'(wa2), 64'(word_idx % 4));
  endtask

  // Monitor: compare every DUT strobe against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (rdata_valid) begin
        if (exp_bytes.size() == 0) check("rdata_valid_expected", 64'd0, 64'd1);
        else begin
          logic [7:0] eb;
          eb = exp_bytes.pop_front();
          check("rdata", 64'(rdata), 64'(eb));
          $display("byte rx 0x%02h", rdata);
        end
      end
      if (ferr) begin
        ferr_seen++;
        $display("ferr pulse");
      end
      if (we) begin
        if (exp_words.size() == 0) check("we_expected", 64'd0, 64'd1);
        else begin
          logic [63:0] ew;
          ew = exp_words.pop_front();
          check("wd", 64'(wd), 64'(ew[63:32]));
          check("wa", 64'(wa), 64'(ew[31:0] % 32768));
          check("word_count_at_we", 64'(word_count), 64'(ew[31:0]));
          check("a2_we_wd", {31'd0, we2, wd2}, {31'd0, 1'b1, ew[63:32]});
          check("a2_wa", 64'(wa2), 64'(ew[31:0] % 4));
          $display("word wr wa=%0d wd=0x%08h a2_wa=%0d", wa, wd, wa2);
        end
      end
    end
  end

  initial begin
    // 1: back-to-back bytes form one word
    apply_reset("t1_reset");
    send_good(8'h55, BIT_NS, 0);
    send_good(8'hAA, BIT_NS, 0);
    send_good(8'h01, BIT_NS, 0);
    send_good(8'h80, BIT_NS, 0);
    finish_test("t1");

    // 2: framing error drops the partial word
    apply_reset("t2_reset");
    send_good(8'hA5, BIT_NS, 0);
    send_good(8'h5A, BIT_NS, 0);
    send_bad(8'hC3);
    send_good(8'h11, BIT_NS, 0);
    send_good(8'h22, BIT_NS, 0);
    send_good(8'h33, BIT_NS, 0);
    send_good(8'h44, BIT_NS, 0);
    finish_test("t2");

    // 3: short glitch is ignored, following byte received
    apply_reset("t3_reset");
    @(posedge clk);
    #9;
    rxd = 1'b0;
    #20;
    rxd = 1'b1;
    #200;
    send_good(8'h3C, BIT_NS, 0);
    finish_test("t3");

    // 4: +5% and -5% bit period, 8 words (also wraps the 2-bit address)
    apply_reset("t4_reset");
    for (int i = 0; i < 16; i++) send_good(8'(i * 37 + 5), 84, 84);
    for (int i = 0; i < 16; i++) send_good(8'(i * 53 + 9), 76, 76);
    finish_test("t4");

    // 5: reset during the third byte abandons the partial word
    apply_reset("t5_reset");
    send_good(8'h12, BIT_NS, 0);
    send_good(8'h34, BIT_NS, 0);
    repeat (10) @(negedge clk);
    fork
      send_frame(8'h56, BIT_NS, 1'b1, 0);
      begin
        #300;
        rstn = 1'b0;
        #3;
        check_reset_outputs("t5_midframe");
      end
    join
    clear_model();
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    send_good(8'hEF, BIT_NS, 0);
    send_good(8'hBE, BIT_NS, 0);
    send_good(8'hAD, BIT_NS, 0);
    send_good(8'hDE, BIT_NS, 0);
    finish_test("t5");
    check("t5_wd_final", 64'(wd), 64'h0000_0000_DEAD_BEEF);

    // 6: five words on the 2-bit-address instance (wa2 0,1,2,3,0)
    apply_reset("t6_reset");
    for (int i = 0; i < 20; i++) send_good(8'(i * 11 + 1), BIT_NS, 0);
    finish_test("t6");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
